fetch_queue_stage: RTL and testbench
====================================

# fetch_queue_stage

Parametrised fetch stage. It holds the program counter, drives the instruction-memory address, and buffers fetched instructions with their PCs in a prefetch queue of configurable depth. It feeds decode through a valid/ready handshake and accepts a branch redirect from decode that flushes the queue. It replaces the fixed single-instruction fetch path with one that supports decode back-pressure and arbitrary address and instruction widths.

## Interface
Parameters:
- ADDR_W, 64, PC and memory address width
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, PC loaded on reset (ADDR_W bits)
- PC_STEP, 4, sequential PC increment

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  instruction-memory address; equals fetch_pc
- imem_instr  in  INSTR_W  instruction at imem_addr, valid in the same cycle (combinational memory read)
- redirect_valid  in  1  branch taken in decode
- redirect_pc  in  ADDR_W  branch target
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of the head instruction
- occupancy  out  $clog2(DEPTH)+1  current number of entries

## Operation
- State: fetch_pc register, DEPTH×(ADDR_W+INSTR_W) storage, rd_ptr, wr_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH), count (0..DEPTH).
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop). A full queue accepts a push in the same cycle as a pop.
- On push, write {fetch_pc, imem_instr} at wr_ptr, increment wr_ptr, and set fetch_pc ← fetch_pc + PC_STEP. The sum wraps modulo 2^ADDR_W with no overflow flag.
- With no push and no redirect, fetch_pc holds and imem_addr stays stable.
- On pop, increment rd_ptr.
- count ← count + push − pop.
- Redirect has highest priority:
  - fetch_pc ← redirect_pc.
  - rd_ptr, wr_ptr and count clear to 0.
  - No push that cycle.
  - out_valid is forced to 0 combinationally that cycle, so no handshake completes.
- out_valid = (count != 0) & !redirect_valid. out_instr and out_pc show the entry at rd_ptr. There is no empty-queue bypass.
- occupancy = count.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0; out_valid = 0; occupancy = 0.
  - out_instr = 0 and out_pc = 0 (storage is cleared).
- Reset asserts asynchronously and deasserts synchronously relative to clk. Reset asserted mid-operation discards all queue contents immediately.
- Fetch-to-decode latency:
  - An instruction fetched in cycle N is at the head in cycle N+1 if the queue was empty.
  - The first instruction after reset release is presented in the second active cycle.
- Redirect latency:
  - Redirect in cycle N gives imem_addr = redirect_pc in cycle N+1.
  - out_valid with out_pc = redirect_pc in cycle N+2.
- Steady state with out_ready held high: one instruction per cycle, occupancy holds at 1.
- Full queue with out_ready low: no push, fetch_pc frozen, head and contents unchanged.
- Full queue with out_ready high: push and pop together, occupancy stays at DEPTH.

## Configuration
- FETCH_STALL_COUNT_EN defined:
  - Adds output stall_cycles (32 bits).
  - Increments once per cycle in which count == DEPTH and pop == 0.
  - Saturates at 2^32−1.
  - Resets to 0 and is not cleared by redirect.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset, then out_ready=1, with memory returning instr = addr[31:0]. Required response:
  - Cycle 1: imem_addr=0.
  - From cycle 2: out_valid=1, with out_pc = 0, 4, 8, … on consecutive cycles.
  - occupancy stays at 1.
- out_ready=0 for 10 cycles with DEPTH=4. Required response:
  - occupancy climbs to 4, then holds.
  - imem_addr freezes at 0x10 and the head stays at pc=0.
  - stall_cycles (macro on) reaches 6.
- Full queue, then out_ready=1 for one cycle. Required response:
  - Head advances to pc=4.
  - The pc=0x10 entry is pushed in the same cycle; occupancy stays 4 and imem_addr becomes 0x14.
- redirect_valid=1 with redirect_pc=0x200 while occupancy=3 and out_ready=1. Required response:
  - Same cycle: out_valid=0.
  - Next cycle: occupancy=0 and imem_addr=0x200.
  - Following cycle: out_valid=1 with out_pc=0x200.
- RESET_PC = 2^64−4 with out_ready=1. Required response: out_pc sequence 0xFFFF_FFFF_FFFF_FFFC, then 0x0, then 0x4.
- Assert reset asynchronously mid-cycle with occupancy=2. Required response:
  - out_valid=0 and occupancy=0 immediately, before the next clock edge.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_stage
//  Purpose  : Instruction fetch stage. Holds the program counter, drives the
//             instruction-memory address and buffers fetched instructions
//             with their PCs in a DEPTH-entry prefetch queue that feeds
//             decode through a valid/ready handshake. A redirect from decode
//             reloads the PC and flushes the queue.
//  Ports    : clk            - clock, rising edge
//             reset          - asynchronous active-low reset
//             imem_addr      - instruction-memory address (= fetch PC)
//             imem_instr     - instruction read combinationally at imem_addr
//             redirect_valid - branch taken in decode
//             redirect_pc    - branch target
//             out_valid      - queue head holds a valid instruction
//             out_ready      - decode accepts the head this cycle
//             out_instr      - head instruction
//             out_pc         - PC of head instruction
//             occupancy      - number of queued entries
//             stall_cycles   - full-and-not-draining cycle counter
//                              (only with FETCH_STALL_COUNT_EN defined)
//  Macro    : FETCH_STALL_COUNT_EN - adds the stall_cycles counter/port
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam int                c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == c_DEPTH);

    // Redirect suppresses valid so no handshake completes while flushing.
    assign out_valid = (r_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    // A full queue can still accept when the head leaves in the same cycle;
    // the write then lands in the slot being vacated (wr_ptr == rd_ptr).
    assign w_push    = !redirect_valid && (!w_full || w_pop);

    assign imem_addr = r_fetch_pc;
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign out_pc    = r_pc_mem[r_rd_ptr];
    assign occupancy = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
                r_instr_mem[r_wr_ptr] <= imem_instr;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
                r_fetch_pc            <= r_fetch_pc + c_PC_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] r_stall_cycles;

    // Counts cycles where the queue is full and nothing drains; survives
    // redirects so it reflects total back-pressure since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (w_full && !w_pop && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue_stage
//  Purpose  : Directed self-checking bench for fetch_queue_stage. A second
//             instance with RESET_PC near the top of the address space
//             exercises PC wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_stage;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  occupancy;

    logic [63:0] b_imem_addr;
    logic [31:0] b_imem_instr;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_instr;
    logic [63:0] b_out_pc;
    logic [2:0]  b_occupancy;
    logic        b_redirect_valid;
    logic [63:0] b_redirect_pc;

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] b_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: instruction word equals the low address bits.
    assign imem_instr   = imem_addr[31:0];
    assign b_imem_instr = b_imem_addr[31:0];

    fetch_queue_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .occupancy      (occupancy)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    fetch_queue_stage #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
    ) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (b_imem_addr),
        .imem_instr     (b_imem_instr),
        .redirect_valid (b_redirect_valid),
        .redirect_pc    (b_redirect_pc),
        .out_valid      (b_out_valid),
        .out_ready      (b_out_ready),
        .out_instr      (b_out_instr),
        .out_pc         (b_out_pc),
        .occupancy      (b_occupancy)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_cycles   (b_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        out_ready        = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        b_out_ready      = 1'b1;
        b_redirect_valid = 1'b0;
        b_redirect_pc    = '0;

        // ---------------- reset values ----------------
        #12;
        check("rst_addr",    imem_addr,   64'h0);
        check("rst_valid",   out_valid,   64'h0);
        check("rst_occ",     occupancy,   64'h0);
        check("rst_instr",   out_instr,   64'h0);
        check("rst_pc",      out_pc,      64'h0);
        check("rst_b_addr",  b_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // ---------------- steady streaming ----------------
        next_cycle();
        reset     = 1'b1;
        out_ready = 1'b1;
        #2;
        check("c1_addr",  imem_addr, 64'h0);
        check("c1_valid", out_valid, 64'h0);
        check("c1_occ",   occupancy, 64'h0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            #2;
            check("str_valid", out_valid, 64'h1);
            check("str_pc",    out_pc,    64'(4 * k));
            check("str_instr", out_instr, 64'(4 * k));
            check("str_occ",   occupancy, 64'h1);
        end

        // ---------------- async reset with two entries ----------------
        next_cycle();
        out_ready = 1'b0;
        next_cycle();
        #2;
        check("pre_rst_occ", occupancy, 64'h2);
        reset = 1'b0;
        #1;
        check("arst_valid",  out_valid, 64'h0);
        check("arst_occ",    occupancy, 64'h0);
        check("arst_addr",   imem_addr, 64'h0);
        check("arst_pc",     out_pc,    64'h0);

        // ---------------- fill with back-pressure ----------------
        next_cycle();
        reset = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            out_ready = 1'b0;
            #2;
            check("fill_occ",  occupancy, 64'((c - 1 > 4) ? 4 : c - 1));
            check("fill_addr", imem_addr, 64'(4 * ((c - 1 > 4) ? 4 : c - 1)));
            if (c >= 2) begin
                check("fill_valid", out_valid, 64'h1);
                check("fill_head",  out_pc,    64'h0);
            end
            case (c)
                1: begin
                    check("wrap_addr",  b_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
                    check("wrap_valid", b_out_valid, 64'h0);
                end
                2: check("wrap_pc0", b_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
                3: check("wrap_pc1", b_out_pc, 64'h0);
                4: check("wrap_pc2", b_out_pc, 64'h4);
                default: ;
            endcase
            next_cycle();
        end

        // Cycle 11: full, release back-pressure for one cycle.
        out_ready = 1'b1;
        #2;
        check("full_valid", out_valid, 64'h1);
        check("full_head",  out_pc,    64'h0);
        check("full_occ",   occupancy, 64'h4);
`ifdef FETCH_STALL_COUNT_EN
        check("stall_6",    stall_cycles, 64'd6);
`endif
        next_cycle();

        // Cycle 12: pop+push happened; now redirect to 0x100 while full.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #2;
        check("pp_head",    out_pc,    64'h4);
        check("pp_occ",     occupancy, 64'h4);
        check("pp_addr",    imem_addr, 64'h14);
        check("rd1_valid",  out_valid, 64'h0);
        next_cycle();

        // Cycle 13: flushed; stall counter kept its value plus the full cycle.
        redirect_valid = 1'b0;
        #2;
        check("rd1_occ",    occupancy, 64'h0);
        check("rd1_addr",   imem_addr, 64'h100);
`ifdef FETCH_STALL_COUNT_EN
        check("stall_7",    stall_cycles, 64'd7);
`endif
        next_cycle();
        next_cycle();
        next_cycle();

        // Cycle 16: three entries queued, redirect with decode ready.
        #2;
        check("pre_rd_occ",  occupancy, 64'h3);
        check("pre_rd_head", out_pc,    64'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        out_ready      = 1'b1;
        #1;
        check("rd2_valid",  out_valid, 64'h0);
        next_cycle();

        redirect_valid = 1'b0;
        #2;
        check("rd2_occ",    occupancy, 64'h0);
        check("rd2_addr",   imem_addr, 64'h200);
        check("rd2_valid1", out_valid, 64'h0);
        next_cycle();
        #2;
        check("rd2_valid2", out_valid, 64'h1);
        check("rd2_pc",     out_pc,    64'h200);
        check("rd2_instr",  out_instr, 64'h200);
        check("rd2_occ1",   occupancy, 64'h1);
        next_cycle();
        #2;
        check("rd2_pc_next", out_pc, 64'h204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
